// File: rtl/pico_io_pkg.sv
// Shared types and constants for the picoMIPS board-input front end.
// Switch state encoding is exposed on the handshake block's debug port.
package pico_io_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } sw_state_t;

    localparam int SW_HS_BIT = 8;
    localparam int SW_DATA_W = 8;

endpackage

// File: rtl/sw_handshake_sync2.sv
// Parameterised-width two-flop synchroniser for asynchronous board inputs.
// Both stages clear to zero on asynchronous active-low reset.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sw_handshake.sv
// Synchronises SW[8:0], debounces the SW[8] handshake switch and captures the
// SW[7:0] data byte on each accepted press, with single-cycle press/release strobes.
module sw_handshake
    import pico_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic [SW_DATA_W:0]   sw_raw,
    output logic [SW_DATA_W-1:0] data_out,
    output logic                 go,
    output logic                 go_pulse,
    output logic                 rel_pulse,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    // Handshake contract: go is the debounced SW[8] level; go_pulse / rel_pulse are
    // one-cycle strobes marking the edges where go rises / falls; no back-pressure.

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_DATA_W:0]   sync;
    logic                 hs;

    sw_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SW_DATA_W-1:0] data_q, data_d;
    logic                 go_q, go_d;
    logic                 go_pulse_q, go_pulse_d;
    logic                 rel_pulse_q, rel_pulse_d;
    logic                 busy_q, busy_d;

    sync2 #(.WIDTH(SW_DATA_W + 1)) u_sync (
        .clk_i  (Clock),
        .rst_ni (nReset),
        .d_i    (sw_raw),
        .q_o    (sync)
    );

    assign hs = sync[SW_HS_BIT];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        go_pulse_d  = 1'b0;
        rel_pulse_d = 1'b0;
        unique case (state_q)
            RELEASED: begin
                if (hs) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!hs) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = PRESSED;
                    cnt_d      = '0;
                    go_pulse_d = 1'b1;
                    data_d     = sync[SW_DATA_W-1:0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!hs) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (hs) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = RELEASED;
                    cnt_d       = '0;
                    rel_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
        // Level outputs follow the next state so they change on the transition edge.
        go_d   = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
        busy_d = (state_d == PRESS_WAIT) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= RELEASED;
            cnt_q       <= '0;
            data_q      <= '0;
            go_q        <= 1'b0;
            go_pulse_q  <= 1'b0;
            rel_pulse_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            go_q        <= go_d;
            go_pulse_q  <= go_pulse_d;
            rel_pulse_q <= rel_pulse_d;
            busy_q      <= busy_d;
        end
    end

    assign data_out  = data_q;
    assign go        = go_q;
    assign go_pulse  = go_pulse_q;
    assign rel_pulse = rel_pulse_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sw_handshake.sv
// Directed bench for sw_handshake with DEBOUNCE_CYCLES = 4 (press/release
// latency of 6 edges after the first sampling edge).
module tb_sw_handshake;
    import pico_io_pkg::*;

    logic       Clock;
    logic       nReset;
    logic [8:0] sw_raw;
    logic [7:0] data_out;
    logic       go;
    logic       go_pulse;
    logic       rel_pulse;
    logic       busy;
    logic [1:0] dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;
    int pulse_errs   = 0;
    logic prev_gp, prev_rp;

    sw_handshake #(.DEBOUNCE_CYCLES(4)) dut (
        .Clock     (Clock),
        .nReset    (nReset),
        .sw_raw    (sw_raw),
        .data_out  (data_out),
        .go        (go),
        .go_pulse  (go_pulse),
        .rel_pulse (rel_pulse),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // strobe rule watcher: never both, never two cycles in a row
    always @(negedge Clock) begin
        if (nReset === 1'b1) begin
            if (go_pulse && rel_pulse) pulse_errs++;
            if (go_pulse && prev_gp) pulse_errs++;
            if (rel_pulse && prev_rp) pulse_errs++;
        end
        prev_gp = go_pulse;
        prev_rp = rel_pulse;
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic apply_reset(input logic [8:0] sw);
        @(negedge Clock);
        nReset = 1'b0;
        sw_raw = sw;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        nReset = 1'b1;
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        sw_raw = 9'h1FF;
        repeat (3) step();
        tests_run++;
        if ({data_out, go, go_pulse, rel_pulse, busy} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got data=%h go=%b gp=%b rp=%b busy=%b, want all 0",
                     data_out, go, go_pulse, rel_pulse, busy);
        end
        tests_run++;
        if (dbg_state !== RELEASED) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d want %0d", dbg_state, RELEASED);
        end
        @(negedge Clock);
        sw_raw = 9'h1A5;
        nReset = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            step();
            tests_run++;
            if (go_pulse !== (j == 7)) begin
                tests_failed++;
                $display("FAIL reset_go_pulse_edge%0d: got %b want %b", j, go_pulse, j == 7);
            end
        end
        tests_run++;
        if (data_out !== 8'hA5 || go !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_first_press: got data=%h go=%b want data=a5 go=1", data_out, go);
        end
        step();
        tests_run++;
        if (go_pulse !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_go_pulse_single: got %b want 0", go_pulse);
        end
    endtask

    task automatic test_bounce_reject();
        logic pattern [12] = '{1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        logic seen_go = 1'b0, seen_gp = 1'b0, seen_busy = 1'b0;
        apply_reset(9'h000);
        for (int i = 0; i < 12; i++) begin
            sw_raw = {pattern[i], 8'h5A};
            step();
            seen_go   |= go;
            seen_gp   |= go_pulse;
            seen_busy |= busy;
        end
        tests_run++;
        if (seen_go !== 1'b0 || seen_gp !== 1'b0) begin
            tests_failed++;
            $display("FAIL bounce_no_press: got go_seen=%b gp_seen=%b want 0 0", seen_go, seen_gp);
        end
        tests_run++;
        if (data_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL bounce_data: got %h want 00", data_out);
        end
        tests_run++;
        if (seen_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL bounce_busy: got busy_seen=%b want 1", seen_busy);
        end
        tests_run++;
        if (dbg_state !== RELEASED || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL bounce_final_state: got state=%0d busy=%b want 0 0", dbg_state, busy);
        end
    endtask

    task automatic test_press_release();
        int gp_count = 0;
        apply_reset(9'h000);
        sw_raw = 9'h13C;
        repeat (10) begin
            step();
            if (go_pulse) gp_count++;
        end
        tests_run++;
        if (gp_count !== 1 || data_out !== 8'h3C || go !== 1'b1) begin
            tests_failed++;
            $display("FAIL press_capture: got pulses=%0d data=%h go=%b want 1 3c 1",
                     gp_count, data_out, go);
        end
        sw_raw = 9'h03C;
        for (int j = 1; j <= 8; j++) begin
            step();
            tests_run++;
            if (rel_pulse !== (j == 7) || go !== (j < 7)) begin
                tests_failed++;
                $display("FAIL release_edge%0d: got rp=%b go=%b want rp=%b go=%b",
                         j, rel_pulse, go, j == 7, j < 7);
            end
        end
    endtask

    task automatic test_data_hold();
        apply_reset(9'h000);
        sw_raw = 9'h13C;
        repeat (10) step();
        sw_raw = 9'h1FF;
        repeat (3) step();
        tests_run++;
        if (data_out !== 8'h3C) begin
            tests_failed++;
            $display("FAIL hold_while_pressed: got %h want 3c", data_out);
        end
        sw_raw = 9'h0FF;
        repeat (10) step();
        tests_run++;
        if (data_out !== 8'h3C || go !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_after_release: got data=%h go=%b want 3c 0", data_out, go);
        end
        sw_raw = 9'h1FF;
        repeat (10) step();
        tests_run++;
        if (data_out !== 8'hFF || go !== 1'b1) begin
            tests_failed++;
            $display("FAIL second_capture: got data=%h go=%b want ff 1", data_out, go);
        end
    endtask

    // Starts from PRESSED, left there by test_data_hold.
    task automatic test_release_bounce();
        int go_low = 0, rp_count = 0, gp_count = 0;
        logic seen_rw = 1'b0;
        sw_raw = 9'h0FF;
        repeat (3) begin
            step();
            if (!go) go_low++;
            if (rel_pulse) rp_count++;
            if (go_pulse) gp_count++;
            seen_rw |= (dbg_state == RELEASE_WAIT);
        end
        sw_raw = 9'h1FF;
        repeat (10) begin
            step();
            if (!go) go_low++;
            if (rel_pulse) rp_count++;
            if (go_pulse) gp_count++;
            seen_rw |= (dbg_state == RELEASE_WAIT);
        end
        tests_run++;
        if (go_low !== 0 || rp_count !== 0 || gp_count !== 0) begin
            tests_failed++;
            $display("FAIL release_bounce: got go_low=%0d rp=%0d gp=%0d want 0 0 0",
                     go_low, rp_count, gp_count);
        end
        tests_run++;
        if (seen_rw !== 1'b1 || dbg_state !== PRESSED) begin
            tests_failed++;
            $display("FAIL release_bounce_state: got rw_seen=%b state=%0d want 1 %0d",
                     seen_rw, dbg_state, PRESSED);
        end
    endtask

    task automatic test_async_reset();
        apply_reset(9'h000);
        sw_raw = 9'h1A5;
        repeat (10) step();
        sw_raw = 9'h0A5;
        repeat (8) step();
        sw_raw = 9'h1A5;
        repeat (4) step();
        tests_run++;
        if (busy !== 1'b1 || dbg_state !== PRESS_WAIT || data_out !== 8'hA5) begin
            tests_failed++;
            $display("FAIL pre_async_reset: got busy=%b state=%0d data=%h want 1 %0d a5",
                     busy, dbg_state, data_out, PRESS_WAIT);
        end
        #2;
        nReset = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || data_out !== 8'h00 || go !== 1'b0 || dbg_state !== RELEASED) begin
            tests_failed++;
            $display("FAIL async_clear: got busy=%b data=%h go=%b state=%0d want 0 00 0 0",
                     busy, data_out, go, dbg_state);
        end
        @(negedge Clock);
        nReset = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            step();
            tests_run++;
            if (go !== (j >= 7) || go_pulse !== (j == 7)) begin
                tests_failed++;
                $display("FAIL post_reset_edge%0d: got go=%b gp=%b want go=%b gp=%b",
                         j, go, go_pulse, j >= 7, j == 7);
            end
        end
        tests_run++;
        if (data_out !== 8'hA5) begin
            tests_failed++;
            $display("FAIL post_reset_capture: got %h want a5", data_out);
        end
    endtask

    task automatic test_pulse_rules();
        tests_run++;
        if (pulse_errs !== 0) begin
            tests_failed++;
            $display("FAIL pulse_rules: got %0d violations want 0", pulse_errs);
        end
    endtask

    initial begin
        prev_gp = 1'b0;
        prev_rp = 1'b0;
        test_reset();
        test_bounce_reject();
        test_press_release();
        test_data_hold();
        test_release_bounce();
        test_async_reset();
        test_pulse_rules();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sw_handshake.md
Name: sw_handshake

Overview:
- User-side front end for the picoMIPS board inputs, feeding the core's switch-driven hold/continue handshake and user-input byte.
- Synchronises the raw SW[8:0] inputs and debounces the SW[8] handshake switch with a 4-state FSM.
- Captures the SW[7:0] data byte at the debounced press and emits single-cycle press/release strobes.
- Sits between the board pins and the core's `usr_input` / `sw8` inputs. SW[9] stays the board reset and is not routed through this block.

Parameters:
- DEBOUNCE_CYCLES, 500000, number of consecutive stable synchronised cycles required to accept a press or release (10 ms at 50 MHz). Legal range 2..2^24.
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width (derived; do not override).

Ports:
- Clock  input  1  system clock, all state on rising edge
- nReset  input  1  asynchronous active-low reset
- sw_raw  input  9  raw switches; [8] = handshake switch, [7:0] = data byte
- data_out  output  8  data byte captured at the last accepted press
- go  output  1  debounced level of sw_raw[8]; drives the core's sw8 input
- go_pulse  output  1  one-cycle strobe on an accepted press
- rel_pulse  output  1  one-cycle strobe on an accepted release
- busy  output  1  high while in PRESS_WAIT or RELEASE_WAIT

Behaviour:
- Reset (nReset low, asynchronous): all synchroniser flops = 0, FSM = RELEASED, counter = 0, data_out = 8'h00, go = 0, go_pulse = 0, rel_pulse = 0, busy = 0. Deasserting reset mid-bounce restarts cleanly from RELEASED.
- Synchroniser: a 2-flop chain on all 9 bits. sync = sw_raw delayed by 2 edges. The FSM uses only sync values.
- Counter: counts cycles inside a WAIT state and clears on every state change.
- FSM states and transitions:
  - RELEASED: if sync[8] = 1, go to PRESS_WAIT with count = 0.
  - PRESS_WAIT: if sync[8] = 0, return to RELEASED (bounce rejected; no strobe, data_out unchanged). Otherwise count++. When count == DEBOUNCE_CYCLES-1 with sync[8] still 1, go to PRESSED.
  - PRESSED: if sync[8] = 0, go to RELEASE_WAIT with count = 0.
  - RELEASE_WAIT: if sync[8] = 1, return to PRESSED (no strobe). Otherwise count++. When count == DEBOUNCE_CYCLES-1, go to RELEASED.
- Outputs are registered and update on the same edge as the state change:
  - go = 1 exactly in PRESSED and RELEASE_WAIT.
  - PRESS_WAIT→PRESSED edge: go_pulse = 1 for one cycle, and data_out <= sync[7:0] at that same edge.
  - RELEASE_WAIT→RELEASED edge: rel_pulse = 1 for one cycle.
- Latency: with raw SW[8] high and stable from sampling edge E0, go and go_pulse assert at edge E0+DEBOUNCE_CYCLES+2. Release is symmetric for go falling and rel_pulse.
- data_out is held between presses. Changes to SW[7:0] while pressed, or during a rejected bounce, do not affect data_out.
- go_pulse and rel_pulse are never high together and never high for two consecutive cycles.
- The counter never wraps: the compare-and-transition occurs at DEBOUNCE_CYCLES-1.

Decomposition:
- Shared package `pico_io_pkg`:
  - `sw_state_t` enum {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT}
  - `SW_HS_BIT = 8`
  - `SW_DATA_W = 8`
- One natural sub-module: `sync2`, a parameterised-width 2-flop synchroniser with asynchronous active-low reset. Reusable for other board inputs.
- FSM, counter and capture stay in `sw_handshake`.

Test Plan (DEBOUNCE_CYCLES = 4):
- Reset: hold nReset = 0 with sw_raw = 9'h1FF → all outputs 0 and state RELEASED. Release reset with sw_raw = 9'h1A5 → go_pulse at 6th edge after first sample; data_out = 8'hA5; go = 1.
- Bounce reject: SW[8] high 2 cycles, low 1, high 2, then low → go never asserts, no go_pulse, data_out stays 8'h00, busy pulses.
- Clean press/release: SW = 9'h13C held 10 cycles, then SW[8] = 0 → go_pulse once with data_out = 8'h3C; rel_pulse once exactly 6 edges after SW[8] falls; go low on the same edge.
- Data hold: after a press capturing 8'h3C, change SW[7:0] to 8'hFF while pressed and through release → data_out remains 8'h3C. Next press captures 8'hFF.
- Release bounce: while PRESSED, SW[8] low 3 cycles, then high → go stays 1, no rel_pulse, no second go_pulse.
- Async reset mid-PRESS_WAIT: pull nReset low between clock edges → outputs clear immediately, without waiting for a clock edge. After release with SW[8] still high, a full DEBOUNCE_CYCLES+2 latency is observed before go.
